// File: rtl/pmp_csr_unit.sv
// Physical memory protection unit: CSR-programmable region table, a one-cycle
// registered access check, and a sticky capture of the first denied access.
module pmp_csr_unit #(
    parameter int PMP_ENTRIES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       csr_valid,
    output logic       csr_ready,
    input  logic       csr_write,
    input  logic [3:0] csr_addr,
    input  logic [7:0] csr_wdata,
    output logic       csr_rvalid,
    output logic [7:0] csr_rdata,
    output logic       csr_err,
    input  logic       req_valid,
    input  logic [7:0] req_addr,
    input  logic [2:0] req_rwx,
    output logic       resp_valid,
    output logic       access_granted,
    output logic       fault_valid,
    output logic [7:0] fault_addr,
    output logic [2:0] fault_rwx,
    input  logic       fault_clr
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t     state_p0, state_nxt;
    logic [7:0] start_p0 [PMP_ENTRIES];
    logic [7:0] end_p0   [PMP_ENTRIES];
    logic [7:0] cfg_p0   [PMP_ENTRIES];

    logic [1:0] csr_idx, csr_fld;
    logic       idx_hit;
    logic [7:0] sel_start, sel_end, sel_cfg;
    logic       csr_accept, err_nxt, wr_en;
    logic [7:0] rdata_nxt;
    logic       match_found, grant_nxt, deny_now;

    assign csr_ready  = (state_p0 == IDLE);
    assign csr_rvalid = (state_p0 == RESP);

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:    if (csr_valid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // CSR decode: the addressed entry is picked by loop so an index beyond the table reads as absent
    always_comb begin
        csr_idx   = csr_addr[3:2];
        csr_fld   = csr_addr[1:0];
        idx_hit   = 1'b0;
        sel_start = 8'h00;
        sel_end   = 8'h00;
        sel_cfg   = 8'h00;
        for (int i = 0; i < PMP_ENTRIES; i++) begin
            if (csr_idx == 2'(i)) begin
                idx_hit   = 1'b1;
                sel_start = start_p0[i];
                sel_end   = end_p0[i];
                sel_cfg   = cfg_p0[i];
            end
        end
        csr_accept = csr_valid && csr_ready;
        err_nxt    = !idx_hit || (csr_fld == 2'd3) || (csr_write && sel_cfg[7]);
        wr_en      = csr_accept && csr_write && !err_nxt;
        rdata_nxt  = 8'h00;
        if (!csr_write && idx_hit) begin
            case (csr_fld)
                2'd0:    rdata_nxt = sel_start;
                2'd1:    rdata_nxt = sel_end;
                2'd2:    rdata_nxt = sel_cfg;
                default: rdata_nxt = 8'h00;
            endcase
        end
    end

    // Access check against the table as it stands before any same-cycle write
    always_comb begin
        match_found = 1'b0;
        grant_nxt   = 1'b0;
        for (int i = 0; i < PMP_ENTRIES; i++) begin
            if (!match_found && cfg_p0[i][3] &&
                (start_p0[i] <= req_addr) && (req_addr <= end_p0[i])) begin
                match_found = 1'b1;
                grant_nxt   = ((req_rwx & ~cfg_p0[i][2:0]) == 3'b000);
            end
        end
        deny_now = req_valid && !grant_nxt;
    end

    // Stage p0 -> p1: state, table and CSR response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0  <= IDLE;
            csr_rdata <= 8'h00;
            csr_err   <= 1'b0;
            for (int i = 0; i < PMP_ENTRIES; i++) begin
                start_p0[i] <= 8'h00;
                end_p0[i]   <= 8'h00;
                cfg_p0[i]   <= 8'h00;
            end
        end else begin
            state_p0 <= state_nxt;
            if (csr_accept) begin
                csr_rdata <= rdata_nxt;
                csr_err   <= err_nxt;
            end
            if (wr_en) begin
                for (int i = 0; i < PMP_ENTRIES; i++) begin
                    if (csr_idx == 2'(i)) begin
                        case (csr_fld)
                            2'd0:    start_p0[i] <= csr_wdata;
                            2'd1:    end_p0[i]   <= csr_wdata;
                            2'd2:    cfg_p0[i]   <= csr_wdata & 8'h8F;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Stage p0 -> p1: check response and fault capture (capture beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid     <= 1'b0;
            access_granted <= 1'b0;
            fault_valid    <= 1'b0;
            fault_addr     <= 8'h00;
            fault_rwx      <= 3'b000;
        end else begin
            resp_valid     <= req_valid;
            access_granted <= req_valid && grant_nxt;
            if (deny_now && (!fault_valid || fault_clr)) begin
                fault_valid <= 1'b1;
                fault_addr  <= req_addr;
                fault_rwx   <= req_rwx;
            end else if (fault_clr) begin
                fault_valid <= 1'b0;
            end
        end
    end

endmodule
